// File: rtl/alu_issue_unit.sv
// alu_issue_unit: issue/retire stage sitting beside an AluExecElement.
// Accepts one decoded ALU op, latches its operands and drives the element.
// Then waits for `completed`, captures `out` and hands it to writeback.
// Optional feature: define ALU_ISSUE_TIMEOUT_EN to abort a WAIT that lasts
// TIMEOUT_CYCLES cycles. The aborted op returns 32'hDEADBEEF with res_error set.
module alu_issue_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TCNT_W         = 7
) (
  input  logic        clk,
  input  logic        reset,
  // Decoded-op handshake
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_inst_num,
  input  logic [31:0] in_const16_x,
  input  logic [4:0]  in_shift5,
  input  logic [31:0] in_rs,
  input  logic [31:0] in_rt,
  input  logic [4:0]  in_dest,
  // Execution element interface
  output logic        elem_reset,
  output logic [5:0]  elem_inst_num,
  output logic [31:0] elem_const16_x,
  output logic [4:0]  elem_shift5,
  output logic [31:0] elem_rs,
  output logic [31:0] elem_rt,
  input  logic        elem_completed,
  input  logic [31:0] elem_out,
  // Writeback handshake
  output logic        res_valid,
  input  logic        res_ready,
  output logic [4:0]  res_dest,
  output logic [31:0] res_value,
  output logic        res_error,
  output logic        busy
);

  // The wait counter must be able to represent TIMEOUT_CYCLES.
  if ((2 ** TCNT_W) <= TIMEOUT_CYCLES) begin : g_tcnt_too_narrow
    $error("alu_issue_unit: TCNT_W too small for TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResult
  } state_e;

  state_e state_q, state_d;

  // Single-cycle strobes decoded from the current state and handshakes
  logic accept;
  logic capture;
  logic retire;
  logic abort;

  // Latched operands
  logic [5:0]  inst_q;
  logic [31:0] const16_q;
  logic [4:0]  shift5_q;
  logic [31:0] rs_q;
  logic [31:0] rt_q;
  logic [4:0]  dest_q;

  // Captured result
  logic [31:0] value_q;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam logic [TCNT_W-1:0] TcntLast = TCNT_W'(TIMEOUT_CYCLES - 1);
  logic [TCNT_W-1:0] tcnt_q;
  logic              error_q;
  logic              limit_hit;

  assign limit_hit = (tcnt_q == TcntLast);
`endif

  // State register; async reset drops any in-flight op
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic and handshake strobes
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    capture = 1'b0;
    retire  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        // A completion arriving on the limit cycle beats the timeout.
        if (elem_completed) begin
          capture = 1'b1;
          state_d = StResult;
        end
`ifdef ALU_ISSUE_TIMEOUT_EN
        else if (limit_hit) begin
          abort   = 1'b1;
          state_d = StResult;
        end
`endif
      end
      StResult: begin
        if (res_ready) begin
          retire  = 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Operand latch; written only on accept so elem_* are stable in WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      inst_q    <= '0;
      const16_q <= '0;
      shift5_q  <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      dest_q    <= '0;
    end else if (accept) begin
      inst_q    <= in_inst_num;
      const16_q <= in_const16_x;
      shift5_q  <= in_shift5;
      rs_q      <= in_rs;
      rt_q      <= in_rt;
      dest_q    <= in_dest;
    end
  end

  // Result capture; held while writeback stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value_q <= '0;
    end else if (capture) begin
      value_q <= elem_out;
    end else if (abort) begin
      value_q <= 32'hDEAD_BEEF;
    end
  end

`ifdef ALU_ISSUE_TIMEOUT_EN
  // Wait counter: cleared on accept, counts each cycle spent in WAIT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tcnt_q <= '0;
    end else if (accept) begin
      tcnt_q <= '0;
    end else if (state_q == StWait && !limit_hit) begin
      tcnt_q <= tcnt_q + 1'b1;
    end
  end

  // Error flag: set by a timeout, cleared by a normal capture or retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      error_q <= 1'b0;
    end else if (abort) begin
      error_q <= 1'b1;
    end else if (capture || retire) begin
      error_q <= 1'b0;
    end
  end

  assign res_error = error_q;
`else
  assign res_error = 1'b0;
`endif

  // State-decoded outputs; elem_reset is high in reset because state is IDLE
  always_comb begin
    in_ready   = (state_q == StIdle);
    busy       = (state_q != StIdle);
    elem_reset = (state_q != StWait);
    res_valid  = (state_q == StResult);
  end

  assign elem_inst_num  = inst_q;
  assign elem_const16_x = const16_q;
  assign elem_shift5    = shift5_q;
  assign elem_rs        = rs_q;
  assign elem_rt        = rt_q;
  assign res_dest       = dest_q;
  assign res_value      = value_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Self-checking bench for alu_issue_unit. A small behavioural stand-in for
// AluExecElement supplies `completed`/`out`: single-cycle ops complete one
// edge after elem_reset drops, DIV takes DivLat edges, unknown ops keep out.
module tb_alu_issue_unit;

`ifdef ALU_ISSUE_TIMEOUT_EN
  localparam int unsigned TimeoutCycles = 8;
`else
  localparam int unsigned TimeoutCycles = 64;
`endif
  localparam int DivLat = 5;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  in_inst_num = '0;
  logic [31:0] in_const16_x = '0;
  logic [4:0]  in_shift5 = '0;
  logic [31:0] in_rs = '0;
  logic [31:0] in_rt = '0;
  logic [4:0]  in_dest = '0;
  logic        elem_reset;
  logic [5:0]  elem_inst_num;
  logic [31:0] elem_const16_x;
  logic [4:0]  elem_shift5;
  logic [31:0] elem_rs;
  logic [31:0] elem_rt;
  logic        elem_completed;
  logic [31:0] elem_out;
  logic        res_valid;
  logic        res_ready = 1'b1;
  logic [4:0]  res_dest;
  logic [31:0] res_value;
  logic        res_error;
  logic        busy;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_issue_unit #(
    .TIMEOUT_CYCLES(TimeoutCycles),
    .TCNT_W        (7)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_inst_num   (in_inst_num),
    .in_const16_x  (in_const16_x),
    .in_shift5     (in_shift5),
    .in_rs         (in_rs),
    .in_rt         (in_rt),
    .in_dest       (in_dest),
    .elem_reset    (elem_reset),
    .elem_inst_num (elem_inst_num),
    .elem_const16_x(elem_const16_x),
    .elem_shift5   (elem_shift5),
    .elem_rs       (elem_rs),
    .elem_rt       (elem_rt),
    .elem_completed(elem_completed),
    .elem_out      (elem_out),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_dest      (res_dest),
    .res_value     (res_value),
    .res_error     (res_error),
    .busy          (busy)
  );

  // Element stand-in
  logic        e_done = 1'b0;
  logic [31:0] e_out = '0;
  int          e_cnt = 0;
  logic        stall = 1'b0;

  function automatic int op_lat(input logic [5:0] op);
    return (op == 6'd12) ? DivLat : 1;
  endfunction

  always @(posedge clk) begin
    if (elem_reset) begin
      e_done <= 1'b0;
      e_cnt  <= 0;
    end else if (!e_done && !stall) begin
      if (e_cnt + 1 >= op_lat(elem_inst_num)) begin
        e_done <= 1'b1;
        case (elem_inst_num)
          6'd8:  e_out <= elem_rs + elem_rt;
          6'd12: e_out <= (elem_rt == 0) ? 32'hFFFF_FFFF : elem_rs / elem_rt;
          6'd16: e_out <= elem_rs << elem_shift5;
          6'd17: e_out <= $unsigned($signed(elem_rs) >>> elem_shift5);
          default: e_out <= e_out;
        endcase
      end else begin
        e_cnt <= e_cnt + 1;
      end
    end
  end
  assign elem_completed = e_done;
  assign elem_out       = e_out;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic [5:0]  inst;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  sh;
    logic [31:0] c16;
    logic [4:0]  dest;
    logic [31:0] exp_val;
    int          exp_lat;
  } vec_t;

  // Issue one op, wait for its result, check it, and retire it when res_ready=1.
  task automatic run_op(input vec_t v, input logic exp_err);
    int  lat;
    bit  stable;
    bit  wait_low;
    @(negedge clk);
    chk({v.name, " in_ready idle"}, 32'(in_ready), 32'd1);
    in_valid     = 1'b1;
    in_inst_num  = v.inst;
    in_rs        = v.rs;
    in_rt        = v.rt;
    in_shift5    = v.sh;
    in_const16_x = v.c16;
    in_dest      = v.dest;
    @(negedge clk);
    in_valid = 1'b0;
    in_rs    = 32'hA5A5_A5A5;
    chk({v.name, " elem_rs"}, elem_rs, v.rs);
    chk({v.name, " elem_inst"}, 32'(elem_inst_num), 32'(v.inst));
    chk({v.name, " elem_c16"}, elem_const16_x, v.c16);
    lat      = 0;
    stable   = 1'b1;
    wait_low = 1'b1;
    while (!res_valid && lat < 200) begin
      if (elem_reset !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b1) wait_low = 1'b0;
      if (elem_rs !== v.rs || elem_rt !== v.rt || elem_shift5 !== v.sh) stable = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({v.name, " latency"}, 32'(lat), 32'(v.exp_lat));
    chk({v.name, " wait ctrl"}, 32'(wait_low), 32'd1);
    chk({v.name, " elem stable"}, 32'(stable), 32'd1);
    chk({v.name, " res_value"}, res_value, v.exp_val);
    chk({v.name, " res_dest"}, 32'(res_dest), 32'(v.dest));
    chk({v.name, " res_error"}, 32'(res_error), 32'(exp_err));
    chk({v.name, " elem_reset result"}, 32'(elem_reset), 32'd1);
    if (res_ready) begin
      @(negedge clk);
      chk({v.name, " retired"}, 32'(res_valid), 32'd0);
      chk({v.name, " idle ready"}, 32'(in_ready), 32'd1);
      chk({v.name, " err cleared"}, 32'(res_error), 32'd0);
    end
  endtask

  vec_t vecs[6];

  initial begin
    bit held;
    bit never;
    int lat;
    vecs[0] = '{"add", 6'd8, 32'd5, 32'd7, 5'd0, 32'd0, 5'd3, 32'd12, 2};
    vecs[1] = '{"sll", 6'd16, 32'h1, 32'd0, 5'd31, 32'd0, 5'd4, 32'h8000_0000, 2};
    vecs[2] = '{"sra", 6'd17, 32'h8000_0000, 32'd0, 5'd4, 32'd0, 5'd5, 32'hF800_0000, 2};
    vecs[3] = '{"div", 6'd12, 32'd100, 32'd7, 5'd0, 32'hFFFF_8000, 5'd6, 32'd14, DivLat + 1};
    vecs[4] = '{"unknown", 6'd63, 32'd9, 32'd9, 5'd0, 32'd0, 5'd7, 32'd14, 2};
    vecs[5] = '{"add wrap", 6'd8, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 5'd31, 32'd0, 2};

    // Reset state
    #12;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst elem_reset", 32'(elem_reset), 32'd1);
    chk("rst res_valid", 32'(res_valid), 32'd0);
    chk("rst res_error", 32'(res_error), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst res_value", res_value, 32'd0);
    chk("rst elem_rs", elem_rs, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_op(vecs[i], 1'b0);

    // Writeback stall: result held, new input ignored, retire on first ready edge
    res_ready = 1'b0;
    run_op('{"stall", 6'd8, 32'h1234_0000, 32'h0000_5678, 5'd0, 32'd0, 5'd9,
             32'h1234_5678, 2}, 1'b0);
    held = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid    = 1'b1;
      in_rs       = 32'h0BAD_0BAD;
      in_dest     = 5'd1;
      in_inst_num = 6'd8;
      @(negedge clk);
      if (res_valid !== 1'b1 || res_value !== 32'h1234_5678 || res_dest !== 5'd9 ||
          in_ready !== 1'b0 || elem_rs !== 32'h1234_0000) held = 1'b0;
    end
    chk("stall held", 32'(held), 32'd1);
    in_valid  = 1'b0;
    res_ready = 1'b1;
    @(negedge clk);
    chk("stall retired", 32'(res_valid), 32'd0);
    chk("stall idle", 32'(in_ready), 32'd1);

    // Async reset in the middle of a DIV
    in_valid    = 1'b1;
    in_inst_num = 6'd12;
    in_rs       = 32'd100;
    in_rt       = 32'd7;
    in_dest     = 5'd2;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid-div elem_reset low", 32'(elem_reset), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort elem_reset", 32'(elem_reset), 32'd1);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    chk("abort busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    never = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (res_valid !== 1'b0 || in_ready !== 1'b1) never = 1'b0;
    end
    chk("abort no result", 32'(never), 32'd1);
    chk("abort res_value", res_value, 32'd0);

`ifdef ALU_ISSUE_TIMEOUT_EN
    stall = 1'b1;
    run_op('{"timeout", 6'd12, 32'd100, 32'd7, 5'd0, 32'd0, 5'd11, 32'hDEAD_BEEF,
             TimeoutCycles}, 1'b1);
    stall = 1'b0;
`endif

    // A last ADD after everything else shows the unit is still usable
    lat = 0;
    run_op('{"post", 6'd8, 32'd40, 32'd2, 5'd0, 32'd0, 5'd12, 32'd42, 2}, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global time limit
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "time limit");
  end

endmodule
